// File: rtl/traffic_ctrl_multi_if.sv
// Lamp-sequencer control/status bundle: run/priority controls in, phase,
// direction, lamp drives and end-of-direction pulse out.
interface traffic_ctrl_multi_if #(
  parameter int N_DIR = 2,
  parameter int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1
) ();
  logic               en;
  logic               pass;
  logic [DIR_W-1:0]   pass_dir;
  logic [4:0]         state;
  logic [DIR_W-1:0]   cur_dir;
  logic [3*N_DIR-1:0] light;
  logic               dir_done;

  modport master (
    output en, pass, pass_dir,
    input  state, cur_dir, light, dir_done
  );

  modport slave (
    input  en, pass, pass_dir,
    output state, cur_dir, light, dir_done
  );
endinterface

// File: rtl/traffic_ctrl_multi.sv
// Round-robin multi-direction traffic-light sequencer with internal phase timer:
// long green, blank/blink-green pulses, yellow, all-red clearance per direction.
module traffic_ctrl_multi #(
  parameter int N_DIR   = 2,
  parameter int N_GREEN = 3,
  parameter int CNT_W   = 8,
  parameter int T_G     = 8,
  parameter int T_GB    = 2,
  parameter int T_NONE  = 2,
  parameter int T_Y     = 3,
  parameter int T_R     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_ctrl_multi_if.slave  bus
);
  localparam int DIR_W = (N_DIR > 1) ? $clog2(N_DIR) : 1;
  localparam int BLK_W = (N_GREEN > 1) ? $clog2(N_GREEN) : 1;

  localparam logic [CNT_W-1:0] G_LAST     = CNT_W'(T_G - 1);
  localparam logic [CNT_W-1:0] GB_LAST    = CNT_W'(T_GB - 1);
  localparam logic [CNT_W-1:0] NONE_LAST  = CNT_W'(T_NONE - 1);
  localparam logic [CNT_W-1:0] Y_LAST     = CNT_W'(T_Y - 1);
  localparam logic [CNT_W-1:0] R_LAST     = CNT_W'(T_R - 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(N_GREEN - 1);
  localparam logic [DIR_W-1:0] DIR_LAST   = DIR_W'(N_DIR - 1);

  typedef enum logic [4:0] {
    ST_INIT = 5'b00001,
    ST_G    = 5'b00010,
    ST_NONE = 5'b00100,
    ST_Y    = 5'b01000,
    ST_R    = 5'b10000
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] t_last;
  logic [BLK_W-1:0] blink;
  logic [DIR_W-1:0] cur_dir;
  logic             legal;
  logic             phase_done;
  logic             pass_hit;

  always_comb begin
    t_last = '0;
    legal  = 1'b1;
    case (state)
      ST_INIT: t_last = '0;
      ST_G:    t_last = (blink == '0) ? G_LAST : GB_LAST;
      ST_NONE: t_last = NONE_LAST;
      ST_Y:    t_last = Y_LAST;
      ST_R:    t_last = R_LAST;
      default: legal  = 1'b0;
    endcase
  end

  assign phase_done = (timer == t_last);

  // A request for the direction already in its long green is a no-op.
  assign pass_hit = bus.pass
                  && ({1'b0, bus.pass_dir} < (DIR_W + 1)'(N_DIR))
                  && !(state == ST_G && blink == '0 && cur_dir == bus.pass_dir);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_INIT;
      timer   <= '0;
      blink   <= '0;
      cur_dir <= '0;
    end else if (pass_hit) begin
      state   <= ST_G;
      timer   <= '0;
      blink   <= '0;
      cur_dir <= bus.pass_dir;
    end else if (!legal) begin
      state   <= ST_INIT;
      timer   <= '0;
      blink   <= '0;
      cur_dir <= '0;
    end else if (bus.en) begin
      timer <= phase_done ? '0 : timer + 1'b1;
      case (state)
        ST_INIT: begin
          state   <= ST_G;
          blink   <= '0;
          cur_dir <= '0;
        end
        ST_G: if (phase_done) state <= (blink == BLINK_LAST) ? ST_Y : ST_NONE;
        ST_NONE: if (phase_done) begin
          state <= ST_G;
          blink <= blink + 1'b1;
        end
        ST_Y: if (phase_done) state <= ST_R;
        ST_R: if (phase_done) begin
          state   <= ST_G;
          blink   <= '0;
          cur_dir <= (cur_dir == DIR_LAST) ? '0 : cur_dir + 1'b1;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  assign bus.state    = state;
  assign bus.cur_dir  = cur_dir;
  assign bus.dir_done = (state == ST_R) && phase_done && bus.en && !pass_hit;

  // Lamp word per direction is {R,Y,G}; everyone but the active direction sees red.
  always_comb begin
    bus.light = {N_DIR{3'b100}};
    for (int d = 0; d < N_DIR; d++) begin
      if (cur_dir == DIR_W'(d)) begin
        case (state)
          ST_G:    bus.light[3*d +: 3] = 3'b001;
          ST_NONE: bus.light[3*d +: 3] = 3'b000;
          ST_Y:    bus.light[3*d +: 3] = 3'b010;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Bench for traffic_ctrl_multi: three configurations run in lockstep against a
// phase-list reference model, plus a constant vector table and corner sequences.
module tb_traffic_ctrl_multi;
  localparam int NC     = 3;
  localparam int K_G    = 1;
  localparam int K_NONE = 2;
  localparam int K_Y    = 3;
  localparam int K_R    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_ctrl_multi_if #(.N_DIR(2)) if0 ();
  traffic_ctrl_multi_if #(.N_DIR(4)) if1 ();
  traffic_ctrl_multi_if #(.N_DIR(3)) if2 ();

  traffic_ctrl_multi #(.N_DIR(2), .N_GREEN(3)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  traffic_ctrl_multi #(.N_DIR(4), .N_GREEN(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  traffic_ctrl_multi #(.N_DIR(3), .N_GREEN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  int checks = 0;
  int errors = 0;

  // Reference model: each direction walks a list of (lamp kind, duration) phases.
  int m_ndir [NC];
  int m_len  [NC];
  int m_kind [NC][8];
  int m_dur  [NC][8];
  bit m_init [NC];
  int m_dir  [NC];
  int m_idx  [NC];
  int m_el   [NC];

  bit cur_en;
  bit cur_pass;
  int cur_pd;

  task automatic push_phase(int c, int kind, int dur);
    m_kind[c][m_len[c]] = kind;
    m_dur[c][m_len[c]]  = dur;
    m_len[c]++;
  endtask

  task automatic build_model(int c, int ndir, int ngreen);
    m_ndir[c] = ndir;
    m_len[c]  = 0;
    push_phase(c, K_G, 8);
    for (int b = 1; b < ngreen; b++) begin
      push_phase(c, K_NONE, 2);
      push_phase(c, K_G, 2);
    end
    push_phase(c, K_Y, 3);
    push_phase(c, K_R, 4);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_init[c] = 1'b1;
      m_dir[c]  = 0;
      m_idx[c]  = 0;
      m_el[c]   = 0;
    end
  endtask

  function automatic int pd_for(int c);
    return (c == 0) ? (cur_pd & 1) : cur_pd;
  endfunction

  function automatic bit model_hit(int c);
    int pd = pd_for(c);
    return cur_pass && (pd < m_ndir[c])
           && !(!m_init[c] && m_idx[c] == 0 && m_dir[c] == pd);
  endfunction

  task automatic model_step(int c);
    if (model_hit(c)) begin
      m_init[c] = 1'b0;
      m_dir[c]  = pd_for(c);
      m_idx[c]  = 0;
      m_el[c]   = 0;
    end else if (cur_en) begin
      if (m_init[c]) begin
        m_init[c] = 1'b0;
        m_dir[c]  = 0;
        m_idx[c]  = 0;
        m_el[c]   = 0;
      end else begin
        m_el[c]++;
        if (m_el[c] == m_dur[c][m_idx[c]]) begin
          m_el[c] = 0;
          m_idx[c]++;
          if (m_idx[c] == m_len[c]) begin
            m_idx[c] = 0;
            m_dir[c] = (m_dir[c] + 1) % m_ndir[c];
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_state(int c);
    if (m_init[c]) return 32'd1;
    return 32'(1 << m_kind[c][m_idx[c]]);
  endfunction

  function automatic logic [31:0] exp_light(int c);
    logic [31:0] l = '0;
    logic [2:0]  lamp;
    for (int d = 0; d < m_ndir[c]; d++) begin
      lamp = 3'b100;
      if (!m_init[c] && d == m_dir[c]) begin
        case (m_kind[c][m_idx[c]])
          K_G:     lamp = 3'b001;
          K_NONE:  lamp = 3'b000;
          K_Y:     lamp = 3'b010;
          default: lamp = 3'b100;
        endcase
      end
      l[3*d +: 3] = lamp;
    end
    return l;
  endfunction

  function automatic logic [31:0] exp_done(int c);
    return 32'(!m_init[c] && cur_en && !model_hit(c) && m_idx[c] == m_len[c] - 1
               && m_el[c] == m_dur[c][m_len[c] - 1] - 1);
  endfunction

  function automatic logic [31:0] act_state(int c);
    case (c)
      0:       return 32'(if0.state);
      1:       return 32'(if1.state);
      default: return 32'(if2.state);
    endcase
  endfunction

  function automatic logic [31:0] act_dir(int c);
    case (c)
      0:       return 32'(if0.cur_dir);
      1:       return 32'(if1.cur_dir);
      default: return 32'(if2.cur_dir);
    endcase
  endfunction

  function automatic logic [31:0] act_light(int c);
    case (c)
      0:       return 32'(if0.light);
      1:       return 32'(if1.light);
      default: return 32'(if2.light);
    endcase
  endfunction

  function automatic logic [31:0] act_done(int c);
    case (c)
      0:       return 32'(if0.dir_done);
      1:       return 32'(if1.dir_done);
      default: return 32'(if2.dir_done);
    endcase
  endfunction

  task automatic check_output(string name, int c, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %0h, expected %0h at %0t", name, c, actual, expected, $time);
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      check_output("model_state", c, act_state(c), exp_state(c));
      check_output("model_dir",   c, act_dir(c),   32'(m_dir[c]));
      check_output("model_light", c, act_light(c), exp_light(c));
      check_output("model_done",  c, act_done(c),  exp_done(c));
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic apply_stimulus(bit r, bit e, bit p, int pd);
    rst          = r;
    cur_en       = e;
    cur_pass     = p;
    cur_pd       = pd;
    if0.en       = e;
    if1.en       = e;
    if2.en       = e;
    if0.pass     = p;
    if1.pass     = p;
    if2.pass     = p;
    if0.pass_dir = 1'(pd);
    if1.pass_dir = 2'(pd);
    if2.pass_dir = 2'(pd);
    if (!r) model_reset();
    @(posedge clk);
    #1;
    if (r) for (int c = 0; c < NC; c++) model_step(c);
    compare_all();
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, 0);
    check_output("reset_state", 0, 32'(if0.state), 32'h01);
    check_output("reset_light", 0, 32'(if0.light), 32'b100100);
    rst = 1'b1;
    #1;
    check_output("init_after_release", 0, 32'(if0.state), 32'h01);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 0);
  endtask

  typedef struct packed {
    logic       en;
    logic       pass;
    logic [1:0] pd;
    logic [4:0] st;
    logic [0:0] cd;
    logic [5:0] lt;
    logic       dd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int         seg_st   [7] = '{2, 4, 2, 4, 2, 8, 16};
    int         seg_len  [7] = '{8, 2, 2, 2, 2, 3, 4};
    logic [2:0] seg_lamp [7] = '{3'b001, 3'b000, 3'b001, 3'b000, 3'b001, 3'b010, 3'b100};
    vec_t       v;
    int         dd_cnt;

    build_model(0, 2, 3);
    build_model(1, 4, 1);
    build_model(2, 3, 2);
    model_reset();

    // Two full direction cycles of the default configuration plus the wrap to dir0.
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 7; s++)
        for (int k = 0; k < seg_len[s]; k++) begin
          v.en   = 1'b1;
          v.pass = 1'b0;
          v.pd   = 2'd0;
          v.st   = 5'(seg_st[s]);
          v.cd   = 1'(d);
          v.lt   = (d == 0) ? {3'b100, seg_lamp[s]} : {seg_lamp[s], 3'b100};
          v.dd   = (s == 6 && k == 3);
          vecs.push_back(v);
        end
    v.st = 5'b00010; v.cd = 1'b0; v.lt = 6'b100001; v.dd = 1'b0;
    vecs.push_back(v);

    do_reset();
    dd_cnt = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(1'b1, vecs[i].en, vecs[i].pass, int'(vecs[i].pd));
      check_output("tbl_state", 0, 32'(if0.state),    32'(vecs[i].st));
      check_output("tbl_dir",   0, 32'(if0.cur_dir),  32'(vecs[i].cd));
      check_output("tbl_light", 0, 32'(if0.light),    32'(vecs[i].lt));
      check_output("tbl_done",  0, 32'(if0.dir_done), 32'(vecs[i].dd));
      if (if0.dir_done) dd_cnt++;
    end
    check_output("dir_done_count", 0, 32'(dd_cnt), 32'd2);

    // Priority request to dir1 during dir0 yellow cycle 2.
    do_reset();
    run(18);
    check_output("y_before_pass", 0, 32'(if0.state), 32'h08);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1);
    check_output("pass_state", 0, 32'(if0.state),    32'h02);
    check_output("pass_dir",   0, 32'(if0.cur_dir),  32'd1);
    check_output("pass_done",  0, 32'(if0.dir_done), 32'd0);
    run(7);
    check_output("pass_long_green", 0, 32'(if0.state), 32'h02);
    run(1);
    check_output("pass_green_end", 0, 32'(if0.state), 32'h04);

    // Same-direction request in long green is ignored; in blink green it restarts.
    do_reset();
    run(4);
    apply_stimulus(1'b1, 1'b1, 1'b1, 0);
    run(3);
    check_output("noeffect_g8", 0, 32'(if0.state), 32'h02);
    run(1);
    check_output("noeffect_none", 0, 32'(if0.state), 32'h04);
    run(2);
    check_output("blink_green", 0, 32'(if0.state), 32'h02);
    apply_stimulus(1'b1, 1'b1, 1'b1, 0);
    run(7);
    check_output("restart_long_green", 0, 32'(if0.state), 32'h02);
    run(1);
    check_output("restart_end", 0, 32'(if0.state), 32'h04);

    // Five frozen cycles in the middle of a blank phase.
    do_reset();
    run(9);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 0);
      check_output("frozen_state", 0, 32'(if0.state), 32'h04);
      check_output("frozen_light", 0, 32'(if0.light), 32'b100000);
    end
    run(1);
    check_output("resume_none", 0, 32'(if0.state), 32'h04);
    run(1);
    check_output("resume_green", 0, 32'(if0.state), 32'h02);

    // Asynchronous reset in the middle of dir1 red clearance.
    do_reset();
    run(44);
    check_output("mid_r_state", 0, 32'(if0.state),   32'h10);
    check_output("mid_r_dir",   0, 32'(if0.cur_dir), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_output("async_state", 0, 32'(if0.state), 32'h01);
    check_output("async_light", 0, 32'(if0.light), 32'b100100);
    compare_all();
    apply_stimulus(1'b0, 1'b1, 1'b0, 0);
    rst = 1'b1;
    run(1);
    check_output("restart_dir0", 0, 32'(if0.cur_dir), 32'd0);
    check_output("restart_g",    0, 32'(if0.light),   32'b100001);

    // Four directions, single green pulse: 15 cycles per direction.
    do_reset();
    run(16);
    check_output("n4_dir1", 1, 32'(if1.cur_dir), 32'd1);
    check_output("n4_g",    1, 32'(if1.state),   32'h02);
    run(30);
    check_output("n4_dir3", 1, 32'(if1.cur_dir), 32'd3);
    run(15);
    check_output("n4_wrap",  1, 32'(if1.cur_dir), 32'd0);
    check_output("n4_light", 1, 32'(if1.light),   32'b100100100001);

    // Randomised run with occasional resets, holds and priority requests.
    do_reset();
    for (int i = 0; i < 800; i++)
      apply_stimulus(($urandom_range(0, 149) != 0), ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 11) == 0), int'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
